// File: rtl/sram_controller_pkg.sv
// Shared constants, state encoding and address helper for the SRAM front end.
package sram_controller_pkg;

  // Geometry shared with the external SRAM model.
  localparam int SRAM_ADDR_LEN = 18;
  localparam int SRAM_DATA_LEN = 32;

  // Byte address that maps onto SRAM word 0 unless overridden.
  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

  // Controller state encoding.
  typedef enum logic [1:0] {
    SRAM_IDLE  = 2'b00,
    SRAM_READ  = 2'b01,
    SRAM_WRITE = 2'b10,
    SRAM_DONE  = 2'b11
  } sram_state_e;

  // Byte address -> SRAM word address: 32-bit modulo offset from the base,
  // dropped to a word index and truncated to the SRAM address width.
  function automatic logic [SRAM_ADDR_LEN-1:0] sram_word_addr(
    input logic [31:0] byte_addr,
    input logic [31:0] base_addr
  );
    return SRAM_ADDR_LEN'((byte_addr - base_addr) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_wait_counter.sv
// Access-time counter: counts cycles spent in an access state and flags the
// last one so the FSM can leave on the following edge.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,       // synchronous, active-low
  input  logic clear,     // hold at zero (outside an access)
  input  logic enable,    // advance once per access cycle
  output logic terminal   // count has reached WAIT_CYCLES-1
);

  // Wide enough to hold WAIT_CYCLES-1; one bit minimum for WAIT_CYCLES=1.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CNT_W-1:0] count_reg;

  // Clear has priority so every access starts counting from zero.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign terminal = (count_reg == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage front end for the external SRAM: turns single-word load/store
// requests into timed SRAM bus cycles and stalls the pipeline via ready.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR,
  parameter int          WAIT_CYCLES = 5
) (
  input  logic                       clk,
  input  logic                       rst,        // synchronous, active-low
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [31:0]                address,
  input  logic [SRAM_DATA_LEN-1:0]   write_data,
  output logic [SRAM_DATA_LEN-1:0]   read_data,
  output logic                       ready,
  output logic                       sram_we_en, // active-low
  output logic [SRAM_ADDR_LEN-1:0]   sram_addr,
  inout  wire  [2*SRAM_DATA_LEN-1:0] sram_dq
);

  sram_state_e              state_reg, state_next;
  logic [SRAM_ADDR_LEN-1:0] sram_addr_reg;
  logic [SRAM_DATA_LEN-1:0] write_data_reg;
  logic [SRAM_DATA_LEN-1:0] read_data_reg;
  logic                     access_busy;
  logic                     wait_done;
  logic                     accept_req;

  // Counter runs only while an access is being timed.
  assign access_busy = (state_reg == SRAM_READ) || (state_reg == SRAM_WRITE);

  // A request is taken only from IDLE; later input changes are ignored.
  assign accept_req = (state_reg == SRAM_IDLE) && (wr_en || rd_en);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (!access_busy),
    .enable   (access_busy),
    .terminal (wait_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= SRAM_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and ready decode; stores win when both requests are present.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    case (state_reg)
      SRAM_IDLE: begin
        ready = ~(rd_en | wr_en);
        if (wr_en) begin
          state_next = SRAM_WRITE;
        end else if (rd_en) begin
          state_next = SRAM_READ;
        end
      end
      SRAM_READ, SRAM_WRITE: begin
        if (wait_done) begin
          state_next = SRAM_DONE;
        end
      end
      SRAM_DONE: begin
        // Pipeline advances on this edge, so never re-accept here.
        ready      = 1'b1;
        state_next = SRAM_IDLE;
      end
      default: begin
        state_next = SRAM_IDLE;
      end
    endcase
  end

  // Capture word address and store data when a request is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_addr_reg  <= '0;
      write_data_reg <= '0;
    end else if (accept_req) begin
      sram_addr_reg <= sram_word_addr(address, BASE_ADDR);
      if (wr_en) begin
        write_data_reg <= write_data;
      end
    end
  end

  // Load result: pick the half of the 64-bit read bus holding our word,
  // sampled on the edge that ends the timed read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      read_data_reg <= '0;
    end else if ((state_reg == SRAM_READ) && wait_done) begin
      read_data_reg <= sram_addr_reg[0] ? sram_dq[2*SRAM_DATA_LEN-1:SRAM_DATA_LEN]
                                        : sram_dq[SRAM_DATA_LEN-1:0];
    end
  end

  assign read_data  = read_data_reg;
  assign sram_addr  = sram_addr_reg;

  // Write strobe held for the whole timed write; the SRAM rewriting the
  // same word every cycle is harmless.
  assign sram_we_en = (state_reg != SRAM_WRITE);

  // Only the low half is ever driven, and only during a write.
  assign sram_dq[SRAM_DATA_LEN-1:0] = (state_reg == SRAM_WRITE) ? write_data_reg
                                                                : {SRAM_DATA_LEN{1'bz}};
  assign sram_dq[2*SRAM_DATA_LEN-1:SRAM_DATA_LEN] = {SRAM_DATA_LEN{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: directed store/load scenarios plus randomized
// requests against a byte-address-keyed reference memory.
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int          W    = 5;
  localparam logic [63:0] SENT = 64'hC0DE_CAFE_F00D_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // Instance with default timing
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, sram_we_en;
  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  wire  [63:0] sram_dq;
  // Instance with single-cycle access
  logic        rd_en1;
  logic        wr_en1 = 1'b0;
  logic [31:0] address1, read_data1;
  logic [31:0] write_data1 = 32'h0;
  logic        ready1, sram_we_en1;
  logic [SRAM_ADDR_LEN-1:0] sram_addr1;
  wire  [63:0] sram_dq1;

  logic probe;   // bench drives a sentinel to prove the bus is released

  sram_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_we_en(sram_we_en), .sram_addr(sram_addr), .sram_dq(sram_dq)
  );

  sram_controller #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1),
    .sram_we_en(sram_we_en1), .sram_addr(sram_addr1), .sram_dq(sram_dq1)
  );

  // SRAM model: 32-bit words, 64-bit read bus returning the even/odd pair.
  logic [31:0] mem [0:63] = '{default: 32'h0};
  always @(posedge clk) if (!sram_we_en) mem[sram_addr[5:0]] <= sram_dq[31:0];
  assign sram_dq = probe ? SENT :
                   (sram_we_en ? {mem[{sram_addr[5:1], 1'b1}], mem[{sram_addr[5:1], 1'b0}]} : 64'bz);

  // Second SRAM model: word n holds 0xA0000000 | n.
  assign sram_dq1 = sram_we_en1 ?
                    {32'hA000_0000 | (32'(sram_addr1) | 32'd1), 32'hA000_0000 | (32'(sram_addr1) & ~32'd1)}
                    : 64'bz;

  // Reference: what a load of a given byte address must return.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_rd;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // One request on the default instance, checked cycle by cycle.
  task automatic do_req(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble);
    int we_low;
    logic [31:0] exp_word;
    we_low   = 0;
    exp_word = (a - 32'd1024) >> 2;
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    #1;
    for (int c = 0; c <= W + 1; c++) begin
      if (c > 0) begin @(posedge clk); #2; end
      check("ready", 64'(ready), 64'(c == W + 1));
      if (!sram_we_en) we_low++;
      if (c == 1) begin
        check("sram_addr", 64'(sram_addr), 64'(exp_word[SRAM_ADDR_LEN-1:0]));
        if (w) check("write_bus", 64'(sram_dq[31:0]), 64'(d));
      end
      if (c == 2 && scramble) begin
        address    = a ^ 32'h0000_0F00;
        write_data = ~d;
      end
    end
    check("we_cycles", 64'(we_low), w ? 64'(W) : 64'd0);
    if (w) begin
      ref_mem[a] = d;
      check("read_data_hold", 64'(read_data), 64'(last_rd));
    end else begin
      check("read_data", 64'(read_data), 64'(ref_read(a)));
      last_rd = ref_read(a);
    end
    $display("txn %s addr=%h data=%h read_data=%h", w ? "WR" : "RD", a, d, read_data);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; probe = 1'b1;
    wr_en = 1'b0; rd_en = 1'b1; address = 32'd1024; write_data = 32'h0;
    rd_en1 = 1'b0; address1 = 32'd1024;
    last_rd = 32'h0;

    // Reset held with a pending load
    repeat (2) begin
      @(posedge clk); #2;
      check("rst_we_en", 64'(sram_we_en), 64'd1);
      check("rst_read_data", 64'(read_data), 64'd0);
      check("rst_bus_free", sram_dq, SENT);
      check("rst_ready_idle", 64'(ready), 64'd0);
      check("rst_sram_addr", 64'(sram_addr), 64'd0);
    end
    rst = 1'b1; rd_en = 1'b0; probe = 1'b0;
    @(posedge clk); #2;
    check("idle_ready", 64'(ready), 64'd1);

    // Store then load
    do_req(1, 0, 32'd1024, 32'hDEADBEEF, 0);
    do_req(0, 1, 32'd1024, 32'h0, 0);
    // Odd word select
    do_req(1, 0, 32'd1024, 32'h11111111, 0);
    do_req(1, 0, 32'd1028, 32'h22222222, 0);
    do_req(0, 1, 32'd1028, 32'h0, 0);
    do_req(0, 1, 32'd1024, 32'h0, 0);
    // Priority and input hold
    do_req(1, 1, 32'd1032, 32'h5, 1);
    do_req(0, 1, 32'd1032, 32'h0, 1);

    // Reset in the third write cycle
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1036; write_data = 32'h0000ABCD;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
    probe = 1'b1; #1;
    check("midrst_we_en", 64'(sram_we_en), 64'd1);
    check("midrst_bus_free", sram_dq, SENT);
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_read_data", 64'(read_data), 64'd0);
    rst = 1'b1; probe = 1'b0;
    ref_mem[32'd1036] = 32'h0000ABCD;  // three write cycles reached the SRAM
    last_rd = 32'h0;
    do_req(0, 1, 32'd1036, 32'h0, 0);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      bit w, r;
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_req(w, r, 32'd1024 + 32'(4 * $urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
    end

    // Back-to-back loads on the single-cycle instance
    @(posedge clk); #1;
    rd_en1 = 1'b1; address1 = 32'd1024;
    #1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      check("b2b_ready", 64'(ready1), 64'(cyc % 3 == 2));
      if (cyc % 3 == 2) begin
        check("b2b_read_data", 64'(read_data1), 64'(32'hA000_0000 | ((address1 - 32'd1024) >> 2)));
        $display("txn RD1 addr=%h read_data=%h", address1, read_data1);
        address1 = address1 + 32'd4 * 32'(cyc + 1);
      end
      @(posedge clk); #2;
    end
    rd_en1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
